// File: rtl/sd_cmd_tx.sv
// -----------------------------------------------------------------------------
// sd_cmd_tx
//
// Serialises one SD-card SPI-mode command frame. A request produces PRE_BITS
// idle ones with CS low, the 48-bit frame {0, 1, cmd, arg, CRC7, 1} sent MSB
// first, and POST_BITS idle ones with CS low. The card can answer during the
// POST window. One bit is sent per rising clk edge.
//
// Build option:
//   SD_CMD_CRC_EN  defined   : CRC7 (x^7 + x^3 + 1, init 0) over the first 40
//                              frame bits, computed serially as they go out.
//                  undefined : CRC7 is a constant chosen from the latched cmd
//                              (0x4A for CMD0, 0x43 for CMD8, 0x7F otherwise).
//
// Ports:
//   clk    in   single clock, one serial bit per rising edge
//   reset  in   asynchronous, active-low reset
//   start  in   request one frame (taken only in IDLE)
//   cmd    in   [5:0]  command index, latched on the accepting edge
//   arg    in   [31:0] command argument, latched on the accepting edge
//   DI     out  serial data to the card (card MOSI), idles high
//   CS     out  card chip select, active-low
//   busy   out  high for PRE_BITS + 48 + POST_BITS cycles per frame
//   done   out  one-cycle pulse in the first IDLE cycle after a frame
// -----------------------------------------------------------------------------
module sd_cmd_tx #(
    parameter int PRE_BITS  = 8,
    parameter int POST_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd,
    input  logic [31:0] arg,
    output logic        DI,
    output logic        CS,
    output logic        busy,
    output logic        done
);

    localparam int MAX_BITS_A = (PRE_BITS > POST_BITS) ? PRE_BITS : POST_BITS;
    localparam int MAX_BITS   = (MAX_BITS_A > 48) ? MAX_BITS_A : 48;
    localparam int CNT_W      = $clog2(MAX_BITS);

    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'((PRE_BITS  > 0) ? PRE_BITS  - 1 : 0);
    localparam logic [CNT_W-1:0] POST_LAST  = CNT_W'((POST_BITS > 0) ? POST_BITS - 1 : 0);
    localparam logic [CNT_W-1:0] CRC_POS    = CNT_W'(40);
    localparam logic [CNT_W-1:0] END_POS    = CNT_W'(47);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(47);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRE   = 2'd1;
    localparam logic [1:0] S_FRAME = 2'd2;
    localparam logic [1:0] S_POST  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [39:0]      shift_q, shift_d;
    logic [6:0]       crc_q,   crc_d;
    logic             done_q,  done_d;

    // Initial CRC register contents at acceptance. With the serial CRC this is
    // the cleared state; otherwise it is already the final CRC to shift out.
    function automatic logic [6:0] crc_init(input logic [5:0] c);
`ifdef SD_CMD_CRC_EN
        crc_init = 7'h00;
`else
        case (c)
            6'd0:    crc_init = 7'h4A;
            6'd8:    crc_init = 7'h43;
            default: crc_init = 7'h7F;
        endcase
`endif
    endfunction

`ifdef SD_CMD_CRC_EN
    function automatic logic [6:0] crc_next(input logic [6:0] c, input logic b);
        logic fb;
        fb       = b ^ c[6];
        crc_next = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        crc_d   = crc_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d = {2'b01, cmd, arg};
                    crc_d   = crc_init(cmd);
                    cnt_d   = '0;
                    state_d = (PRE_BITS > 0) ? S_PRE : S_FRAME;
                end
            end

            S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FRAME;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_FRAME: begin
                // Bits 0..39 come from the shift register (and feed the CRC);
                // bits 40..46 are shifted out of the CRC register itself.
                if (cnt_q < CRC_POS) begin
                    shift_d = {shift_q[38:0], 1'b0};
`ifdef SD_CMD_CRC_EN
                    crc_d   = crc_next(crc_q, shift_q[39]);
`endif
                end else if (cnt_q < END_POS) begin
                    crc_d = {crc_q[5:0], 1'b0};
                end

                if (cnt_q == FRAME_LAST) begin
                    cnt_d = '0;
                    if (POST_BITS > 0) begin
                        state_d = S_POST;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_POST: begin
                if (cnt_q == POST_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            crc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            crc_q   <= crc_d;
            done_q  <= done_d;
        end
    end

    // Outputs are decoded from state so an asserted reset takes effect at once.
    always_comb begin
        DI   = 1'b1;
        CS   = 1'b1;
        busy = 1'b0;
        case (state_q)
            S_PRE, S_POST: begin
                CS   = 1'b0;
                busy = 1'b1;
            end
            S_FRAME: begin
                CS   = 1'b0;
                busy = 1'b1;
                if (cnt_q < CRC_POS) begin
                    DI = shift_q[39];
                end else if (cnt_q < END_POS) begin
                    DI = crc_q[6];
                end
            end
            default: ;
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// -----------------------------------------------------------------------------
// tb_sd_cmd_tx
//
// Directed bench for sd_cmd_tx with the default 8/8 idle windows. Checks the
// reset state, the CMD0 / CMD8 / CMD17 frames, busy length and done pulse,
// ignored start and argument changes mid-frame, reset mid-frame, and
// back-to-back transactions with start held high.
// -----------------------------------------------------------------------------
module tb_sd_cmd_tx;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic        DI;
    logic        CS;
    logic        busy;
    logic        done;

    int n_checks;
    int n_pass;

    sd_cmd_tx #(
        .PRE_BITS  (8),
        .POST_BITS (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .cmd   (cmd),
        .arg   (arg),
        .DI    (DI),
        .CS    (CS),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge. Requests one frame and checks the whole
    // transaction, returning at the falling edge inside the done cycle.
    // With disturb set, start is pulsed and cmd/arg are changed at frame bit 20.
    task automatic run_frame(input string tag, input logic [5:0] c, input logic [31:0] a,
                             input logic [47:0] exp_frame, input bit disturb);
        logic [7:0]  pre_bits;
        logic [47:0] frame_bits;
        logic [7:0]  post_bits;
        int          busy_cnt;
        int          cs_high;
        int          done_cnt;
        pre_bits   = '0;
        frame_bits = '0;
        post_bits  = '0;
        busy_cnt   = 0;
        cs_high    = 0;
        done_cnt   = 0;
        cmd   = c;
        arg   = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i < 8)       pre_bits   = {pre_bits[6:0], DI};
            else if (i < 56) frame_bits = {frame_bits[46:0], DI};
            else             post_bits  = {post_bits[6:0], DI};
            busy_cnt += int'(busy);
            cs_high  += int'(CS);
            done_cnt += int'(done);
            if (disturb && i == 28) begin
                start = 1'b1;
                cmd   = 6'h3F;
                arg   = 32'hDEADBEEF;
            end
            if (disturb && i == 29) begin
                start = 1'b0;
                cmd   = 6'h15;
                arg   = 32'h12345678;
            end
            @(negedge clk);
        end
        check({tag, "_pre"},   64'(pre_bits),   64'hFF);
        check({tag, "_frame"}, 64'(frame_bits), 64'(exp_frame));
        check({tag, "_post"},  64'(post_bits),  64'hFF);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd64);
        check({tag, "_cs_high_in_txn"}, 64'(cs_high), 64'd0);
        check({tag, "_early_done"}, 64'(done_cnt), 64'd0);
        check({tag, "_done_pulse"}, 64'(done), 64'd1);
        check({tag, "_idle_busy"},  64'(busy), 64'd0);
        check({tag, "_idle_cs"},    64'(CS),   64'd1);
        check({tag, "_idle_di"},    64'(DI),   64'd1);
    endtask

    logic [47:0] exp_cmd17;
    int          extra_busy;
    int          extra_done;
    int          pat_err;
    int          b2b_done;

    initial begin
        n_checks = 0;
        n_pass   = 0;
`ifdef SD_CMD_CRC_EN
        exp_cmd17 = 48'h510000000055;
`else
        exp_cmd17 = 48'h5100000000FF;
`endif
        reset = 1'b0;
        start = 1'b0;
        cmd   = '0;
        arg   = '0;

        #1;
        check("rst_di",   64'(DI),   64'd1);
        check("rst_cs",   64'(CS),   64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);

        // Start in the same cycle reset is released: taken on the first edge.
        reset = 1'b1;
        run_frame("cmd0", 6'd0, 32'h0, 48'h400000000095, 1'b0);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);

        run_frame("cmd8",  6'd8,  32'h000001AA, 48'h48000001AA87, 1'b0);
        run_frame("cmd17", 6'd17, 32'h0,        exp_cmd17,        1'b0);
        @(negedge clk);

        // Start pulse and cmd/arg changes at frame bit 20 must not disturb it.
        run_frame("disturb", 6'd0, 32'h0, 48'h400000000095, 1'b1);
        extra_busy = 0;
        extra_done = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            extra_busy += int'(busy);
            extra_done += int'(done);
        end
        check("no_queued_busy", 64'(extra_busy), 64'd0);
        check("no_queued_done", 64'(extra_done), 64'd0);

        // Reset at frame bit 30.
        cmd   = 6'd0;
        arg   = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (38) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_di",   64'(DI),   64'd1);
        check("midrst_cs",   64'(CS),   64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        extra_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            extra_done += int'(done) + int'(busy);
        end
        check("midrst_quiet", 64'(extra_done), 64'd0);
        reset = 1'b1;
        run_frame("after_rst", 6'd0, 32'h0, 48'h400000000095, 1'b0);

        // start held high: each done cycle accepts the next request.
        pat_err  = 0;
        b2b_done = 0;
        cmd   = 6'd0;
        arg   = 32'h0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 195; i++) begin
            if ((i % 65) < 64) begin
                if (CS !== 1'b0 || busy !== 1'b1 || done !== 1'b0) pat_err++;
            end else begin
                if (CS !== 1'b1 || busy !== 1'b0 || done !== 1'b1) pat_err++;
            end
            b2b_done += int'(done);
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_pattern_errors", 64'(pat_err),  64'd0);
        check("b2b_done_count",     64'(b2b_done), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
